pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width in bits, legal range 8..64.
REQ-002 Parameter STAGES, default 2: number of pipeline register stages, legal range 1..4.
REQ-003 Parameter SAT_MODE, default ADD_WRAP (adder_pkg::add_mode_t): selects ADD_WRAP (modulo 2^DATA_W) or ADD_SAT (unsigned saturate).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 din0  input  DATA_W  unsigned operand A.
REQ-007 din1  input  DATA_W  unsigned operand B.
REQ-008 din_valid  input  1  operands valid this cycle.
REQ-009 din_ready  output  1  block accepts operands this cycle.
REQ-010 dout  output  DATA_W  result.
REQ-011 dout_ovf  output  1  carry-out of the full-width sum for this result.
REQ-012 dout_valid  output  1  result valid.
REQ-013 dout_ready  input  1  downstream accepts result.

Function
REQ-014 A transfer SHALL occur on an input port when din_valid and din_ready are both 1 at a rising edge; an output transfer when dout_valid and dout_ready are both 1.
REQ-015 The block SHALL compute sum = din0 + din1 at DATA_W+1 bits in stage 1; dout_ovf = sum[DATA_W].
REQ-016 In ADD_WRAP, dout SHALL equal sum[DATA_W-1:0]; in ADD_SAT, dout SHALL equal all-ones when sum[DATA_W]=1, else sum[DATA_W-1:0].
REQ-017 Stages 2..STAGES SHALL carry {dout, dout_ovf, valid} unchanged; dout_valid is the valid bit of the last stage.
REQ-018 Stage i SHALL load from stage i-1 (or inputs, for i=1) when stage i is empty or stage i+1 loads (last stage: dout_ready=1); otherwise it holds.
REQ-019 din_ready SHALL equal (stage 1 empty) OR (stage 1 loads this cycle); it SHALL not depend combinationally on din_valid.
REQ-020 With dout_ready held 1, latency from input transfer to dout_valid SHALL be exactly STAGES cycles; throughput one result per cycle.
REQ-021 With dout_ready held 0, the pipeline SHALL absorb up to STAGES transfers, then drive din_ready=0; no result SHALL be dropped, duplicated, or reordered.
REQ-022 While dout_valid=1 and dout_ready=0, dout and dout_ovf SHALL remain stable.
REQ-023 Simultaneous output and input transfer on a full pipeline SHALL advance every stage by one with no bubble.
REQ-024 Data presented with din_valid=0 SHALL never appear as a valid result.

Reset
REQ-025 On rst=1 at a rising edge, all stage valid bits SHALL clear; dout=0, dout_ovf=0, dout_valid=0 on the following cycle.
REQ-026 Reset mid-operation SHALL discard all in-flight results; din_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 Data registers need not clear except the last stage, which SHALL clear to 0.

Structure
REQ-028 adder_pkg SHALL hold add_mode_t {ADD_WRAP, ADD_SAT} and constants MIN_DATA_W, MAX_DATA_W, MAX_STAGES.
REQ-029 One sub-module, adder_pipe_stage (one valid/ready register slice, width-parametrised), SHALL be instantiated STAGES times via generate.
REQ-030 Illegal parameter values SHALL be rejected by an elaboration-time check.

Verification
REQ-031 DATA_W=32, STAGES=2, dout_ready=1; din0=5, din1=7 for one cycle -> dout=12, dout_ovf=0, dout_valid for exactly 1 cycle, 2 cycles after input.
REQ-032 ADD_WRAP, din0=32'hFFFF_FFFF, din1=2 -> dout=1, dout_ovf=1; ADD_SAT same inputs -> dout=32'hFFFF_FFFF, dout_ovf=1.
REQ-033 STAGES=3, dout_ready=0, 5 back-to-back inputs 1..5 -> din_ready drops after 3 accepted; releasing dout_ready yields 1..5 (+0 partner) in order, none lost.
REQ-034 Continuous 100 random transfers with random dout_ready toggling -> scoreboard matches every result in order; dout stable while stalled.
REQ-035 3 items in flight, rst pulsed 1 cycle -> dout_valid=0 and dout=0 next cycle, no stale result ever emitted, din_ready=1 after reset.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and parameter limits for the pipelined adder.
package adder_pkg;

    typedef enum logic {
        ADD_WRAP = 1'b0,
        ADD_SAT  = 1'b1
    } add_mode_t;

    localparam int unsigned MIN_DATA_W = 8;
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned MIN_STAGES = 1;
    localparam int unsigned MAX_STAGES = 4;

endpackage

// File: rtl/adder_pipe_stage.sv
// One valid/ready register slice; loads whenever it is empty or its downstream slice loads.
module adder_pipe_stage #(
    parameter int unsigned WIDTH      = 33,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             next_load,
    output logic             load,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    assign load = !out_valid || next_load;

    // Data only captures real items, so bubbles never overwrite the held value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            if (CLEAR_DATA) begin
                out_data <= '0;
            end
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Unsigned adder with wrap/saturate result and a STAGES-deep valid/ready register pipeline.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned STAGES   = 2,
    parameter add_mode_t   SAT_MODE = ADD_WRAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_ovf,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam int unsigned SW   = DATA_W + 1;
    localparam int unsigned LAST = STAGES - 1;

    if (DATA_W < MIN_DATA_W || DATA_W > MAX_DATA_W ||
        STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_param
        $error("pipelined_adder: DATA_W must be 8..64 and STAGES 1..4");
    end

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] result;

    always_comb begin
        sum    = {1'b0, din0} + {1'b0, din1};
        result = sum[DATA_W-1:0];
        if (SAT_MODE == ADD_SAT && sum[DATA_W]) begin
            result = '1;
        end
    end

    // Each slice carries {result, carry}; valid travels alongside.
    logic [SW-1:0] stage_data  [STAGES];
    logic          stage_valid [STAGES];
    logic          stage_load  [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] in_data;
        logic          in_valid;
        logic          next_load;

        if (k == 0) begin : g_first
            assign in_data  = {result, sum[DATA_W]};
            assign in_valid = din_valid;
        end else begin : g_chain
            assign in_data  = stage_data[k-1];
            assign in_valid = stage_valid[k-1];
        end

        if (k == LAST) begin : g_tail
            assign next_load = dout_ready;
        end else begin : g_body
            assign next_load = stage_load[k+1];
        end

        adder_pipe_stage #(
            .WIDTH      (SW),
            .CLEAR_DATA (k == LAST)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data),
            .in_valid  (in_valid),
            .next_load (next_load),
            .load      (stage_load[k]),
            .out_data  (stage_data[k]),
            .out_valid (stage_valid[k])
        );
    end

    assign din_ready  = stage_load[0];
    assign dout       = stage_data[LAST][SW-1:1];
    assign dout_ovf   = stage_data[LAST][0];
    assign dout_valid = stage_valid[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboard checks for pipelined_adder in wrap, saturate and 3-stage builds.
module tb_pipelined_adder;
    import adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din0, din1;
    logic        dv2, dr2, dv3, dr3;
    logic        rdy_w, rdy_s, rdy_3;
    logic [31:0] do_w, do_s, do_3;
    logic        ovf_w, ovf_s, ovf_3;
    logic        vw, vs, v3;

    always #5 clk = ~clk;

    pipelined_adder #(.DATA_W(32), .STAGES(2), .SAT_MODE(ADD_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .din0(din0), .din1(din1), .din_valid(dv2), .din_ready(rdy_w),
        .dout(do_w), .dout_ovf(ovf_w), .dout_valid(vw), .dout_ready(dr2));

    pipelined_adder #(.DATA_W(32), .STAGES(2), .SAT_MODE(ADD_SAT)) u_sat (
        .clk(clk), .rst(rst), .din0(din0), .din1(din1), .din_valid(dv2), .din_ready(rdy_s),
        .dout(do_s), .dout_ovf(ovf_s), .dout_valid(vs), .dout_ready(dr2));

    pipelined_adder #(.DATA_W(32), .STAGES(3), .SAT_MODE(ADD_WRAP)) u_s3 (
        .clk(clk), .rst(rst), .din0(din0), .din1(din1), .din_valid(dv3), .din_ready(rdy_3),
        .dout(do_3), .dout_ovf(ovf_3), .dout_valid(v3), .dout_ready(dr3));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] wrap;
        logic [31:0] sat;
        logic        ovf;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          sent, got, first_c, last_c, outs, stale;
        logic        in_go, out_go, stall;
        logic [31:0] prev_w, prev_s;
        logic        prev_o;
        logic [32:0] s;
        exp_t        e;

        rst = 1'b1; din0 = '0; din1 = '0;
        dv2 = 1'b0; dr2 = 1'b1; dv3 = 1'b0; dr3 = 1'b1;
        tick; tick;
        rst = 1'b0;
        #1;
        check("rst_valid_w", vw, 0);
        check("rst_dout_w", do_w, 0);
        check("rst_ovf_w", ovf_w, 0);
        check("rst_valid_3", v3, 0);
        check("rst_dout_3", do_3, 0);
        check("rst_ready_w", rdy_w, 1);
        check("rst_ready_3", rdy_3, 1);

        // 5 + 7 through two stages
        din0 = 32'd5; din1 = 32'd7; dv2 = 1'b1;
        tick;
        dv2 = 1'b0; din0 = '0; din1 = '0;
        check("lat_not_yet", vw, 0);
        tick;
        check("sum_valid", vw, 1);
        check("sum_dout", do_w, 12);
        check("sum_ovf", ovf_w, 0);
        check("sum_dout_sat", do_s, 12);
        tick;
        check("sum_one_cycle", vw, 0);

        // carry-out: wrap vs saturate
        din0 = 32'hFFFF_FFFF; din1 = 32'd2; dv2 = 1'b1;
        tick;
        dv2 = 1'b0;
        tick;
        check("wrap_valid", vw, 1);
        check("wrap_dout", do_w, 1);
        check("wrap_ovf", ovf_w, 1);
        check("sat_dout", do_s, 32'hFFFF_FFFF);
        check("sat_ovf", ovf_s, 1);
        tick;

        // 3-stage fill with output stalled
        dr3 = 1'b0; sent = 0;
        for (int c = 0; c < 5; c++) begin
            din0 = sent + 1; din1 = '0; dv3 = 1'b1;
            #1;
            check("fill_ready", rdy_3, (c < 3));
            if (rdy_3) sent++;
            tick;
        end
        check("fill_accepted", sent, 3);
        check("fill_head_valid", v3, 1);
        check("fill_head_dout", do_3, 1);

        // release: stream must drain 1..5 back-to-back
        dr3 = 1'b1; got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (sent < 5) begin
                din0 = sent + 1; dv3 = 1'b1;
            end else begin
                dv3 = 1'b0;
            end
            #1;
            in_go = dv3 && rdy_3;
            if (v3) begin
                check("drain_order", do_3, got + 1);
                check("drain_ovf", ovf_3, 0);
                if (got == 0) first_c = c;
                last_c = c;
                got++;
            end
            if (in_go) sent++;
            tick;
        end
        dv3 = 1'b0;
        check("drain_count", got, 5);
        check("drain_no_bubble", last_c - first_c, 4);

        // random traffic against a scoreboard, with stall stability
        outs = 0;
        for (int c = 0; c < 3000 && outs < 100; c++) begin
            din0 = $urandom; din1 = $urandom;
            dv2 = ($urandom_range(0, 3) != 0);
            dr2 = ($urandom_range(0, 2) != 0);
            #1;
            in_go  = dv2 && rdy_w;
            out_go = vw && dr2;
            stall  = vw && !dr2;
            prev_w = do_w; prev_s = do_s; prev_o = ovf_w;
            if (out_go) begin
                check("rand_sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rand_wrap", do_w, e.wrap);
                    check("rand_sat", do_s, e.sat);
                    check("rand_ovf", ovf_w, e.ovf);
                end
                outs++;
            end
            if (in_go) begin
                s = {1'b0, din0} + {1'b0, din1};
                e.wrap = s[31:0];
                e.sat  = s[32] ? 32'hFFFF_FFFF : s[31:0];
                e.ovf  = s[32];
                sb.push_back(e);
            end
            tick;
            if (stall) begin
                check("stall_valid", vw, 1);
                check("stall_dout", do_w, prev_w);
                check("stall_dout_sat", do_s, prev_s);
                check("stall_ovf", ovf_w, prev_o);
            end
        end
        dv2 = 1'b0; dr2 = 1'b1;
        check("rand_count", outs, 100);

        // reset with three items in flight
        dr3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din0 = 32'd100 + i; din1 = i; dv3 = 1'b1;
            #1;
            check("flight_ready", rdy_3, 1);
            tick;
        end
        dv3 = 1'b0;
        check("flight_valid", v3, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("midrst_valid", v3, 0);
        check("midrst_dout", do_3, 0);
        check("midrst_ovf", ovf_3, 0);
        check("midrst_ready", rdy_3, 1);
        check("midrst_valid_w", vw, 0);
        dr3 = 1'b1; stale = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (v3) stale++;
        end
        check("no_stale", stale, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
